dmem_dump_arbiter: RTL and testbench
====================================

DMEM_DUMP_ARBITER -- requirements
Module: dmem_dump_arbiter

Interface
REQ-001 Parameter DEPTH, default 32: number of 32-bit data-memory words walked by a dump.
REQ-002 Parameter ADDR_W, default 5: memory word-address width; the relation DEPTH <= 2**ADDR_W SHALL hold.
REQ-003 clk  in  1  system clock, all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 pipe_op  in  2  pipeline memory request: 00 idle, 01 write, 10 read, 11 treated as idle.
REQ-006 pipe_addr  in  ADDR_W  pipeline word address.
REQ-007 pipe_wdata  in  32  pipeline write data.
REQ-008 pipe_stall  out  1  pipeline request not granted this cycle; the pipeline holds its request.
REQ-009 dump_start  in  1  single-cycle pulse requesting a full memory dump.
REQ-010 dump_busy  out  1  dump in progress.
REQ-011 dump_done  out  1  single-cycle pulse at dump completion.
REQ-012 mem_op / mem_addr / mem_wdata  out  2 / ADDR_W / 32  granted request to the memory, same encoding as pipe_op.
REQ-013 mem_rdata  in  32  memory read data, valid the cycle after a read is issued.
REQ-014 tx_valid / tx_data  out  1 / 8  byte stream to the debug UART transmitter.
REQ-015 tx_ready  in  1  transmitter accepts tx_data when tx_valid and tx_ready are both high.

Function
REQ-016 FSM states: IDLE, RD, CAP, SEND, DONE.
REQ-017 IDLE: dump_start=1 SHALL load addr counter=0 and move to RD next cycle; dump_start in any other state SHALL be ignored.
REQ-018 RD: memory is driven with op=10 at the dump address (one cycle); next state CAP.
REQ-019 CAP: mem_rdata is latched into a 32-bit shift register, byte index=0; next state SEND.
REQ-020 SEND: tx_valid=1, tx_data=the byte selected by the byte index, MSB first (bits 31:24 first); tx_data is held stable until the handshake.
REQ-021 Each handshake advances the byte index; the handshake on byte 3 SHALL go to RD with addr+1, or to DONE if addr==DEPTH-1.
REQ-022 DONE: dump_done=1 for exactly one cycle; next state IDLE.
REQ-023 dump_busy SHALL be 1 in RD, CAP, SEND and DONE, and 0 in IDLE.
REQ-024 Arbitration in RD: the dump owns the memory; a non-idle pipe_op SHALL see pipe_stall=1 and SHALL NOT reach the memory.
REQ-025 Arbitration in all other states: the pipe_* inputs pass combinationally to mem_*, and pipe_stall=0.
REQ-026 With pipe_op idle and no dump read pending, mem_op SHALL be 00.
REQ-027 A pipeline write during SEND SHALL NOT alter the word already latched; later addresses SHALL reflect the write.
REQ-028 Latency from dump_start to the first tx_valid: 3 cycles (IDLE->RD->CAP->SEND).
REQ-029 Minimum dump length with tx_ready held high: 1 + DEPTH*(1+1+4) + 1 cycles.
REQ-030 The address counter SHALL NOT wrap; termination is decided only by the addr==DEPTH-1 compare.

Reset
REQ-031 Asserting rst at any time, including mid-dump or mid-handshake, SHALL immediately force state IDLE, addr=0, byte index=0, shift register=0.
REQ-032 Output values during reset: tx_valid=0, tx_data=0, dump_busy=0, dump_done=0, pipe_stall=0, and mem_* equal to the pass-through of pipe_*.
REQ-033 After rst deasserts, a dump SHALL require a new dump_start; an interrupted dump is not resumed.

Structure
REQ-034 A shared package dmem_pkg SHALL hold the op encoding constants (OP_IDLE, OP_WRITE, OP_READ) and the FSM state enum.
REQ-035 The byte serialiser (shift register, byte index, valid/ready handshake) SHALL be one sub-module, word_tx_serializer; the FSM, counter and arbitration mux SHALL live in the top module.

Verification
REQ-036 Memory preloaded with word[i]=0x11223300+i, tx_ready=1, dump_start -> bytes 11,22,33,00,11,22,33,01,... ; 128 bytes in total; dump_done one cycle after the last byte.
REQ-037 tx_ready toggled randomly during the dump -> byte stream identical to the REQ-036 stream, with tx_data stable while tx_valid=1 and tx_ready=0.
REQ-038 Pipeline read of addr 5 issued while the FSM is in RD -> pipe_stall=1 for that cycle; the read is granted on the next cycle, and mem_rdata=word[5].
REQ-039 Pipeline write of 0xDEADBEEF to addr 31 during the dump of addr 2 -> the dump emits DE,AD,BE,EF for addr 31.
REQ-040 rst pulsed while byte 2 of addr 7 is pending -> tx_valid=0 and dump_busy=0 immediately; a new dump_start restarts the dump at addr 0.
REQ-041 dump_start asserted mid-dump -> ignored; exactly one dump_done pulse is produced.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared definitions for the data-memory dump arbiter: memory
//             operation encoding, dump FSM state type and an op-decode helper.
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Memory request encoding shared by the pipeline and memory sides.
    // Code 2'b11 is not a legal request and behaves as idle.
    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } dump_state_t;

    // True only for the two request codes that actually touch memory.
    function automatic logic op_is_active(input logic [1:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/word_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : word_tx_serializer
//  Purpose  : Latches one 32-bit word and presents it as four bytes, most
//             significant byte first, over a valid/ready handshake.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             load            - capture load_word and start a new word
//             load_word[31:0] - word to serialise
//             tx_ready        - downstream accepts the current byte
//             tx_valid        - a byte is on offer
//             tx_data[7:0]    - byte on offer (0 when nothing is offered)
//             word_done       - handshake of the fourth byte this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module word_tx_serializer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        word_done
);

    logic [31:0] r_shift;
    logic [1:0]  r_idx;
    logic        r_valid;
    logic        w_hs;
    logic [7:0]  w_byte;

    assign w_hs = r_valid && tx_ready;

    // The word is held intact and the outgoing byte is chosen by the index,
    // so tx_data cannot change while a byte waits for tx_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_shift <= load_word;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (w_hs) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                r_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            2'd0:    w_byte = r_shift[31:24];
            2'd1:    w_byte = r_shift[23:16];
            2'd2:    w_byte = r_shift[15:8];
            default: w_byte = r_shift[7:0];
        endcase
    end

    assign tx_valid  = r_valid;
    assign tx_data   = r_valid ? w_byte : 8'h00;
    assign word_done = w_hs && (r_idx == 2'd3);

endmodule : word_tx_serializer
`default_nettype wire

// File: rtl/dmem_dump_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_dump_arbiter
//  Purpose  : Shares one data memory between the CPU pipeline and a debug
//             dump engine that walks all DEPTH words and streams them, MSB
//             first, to a UART transmitter.
//  Ports    : clk, rst                       - clock, async active-high reset
//             pipe_op/pipe_addr/pipe_wdata   - pipeline memory request
//             pipe_stall                     - pipeline request not granted
//             dump_start                     - pulse: begin a full dump
//             dump_busy / dump_done          - dump in progress / finished
//             mem_op/mem_addr/mem_wdata      - granted request to memory
//             mem_rdata                      - read data, one cycle latency
//             tx_valid/tx_data/tx_ready      - byte stream to the UART
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_dump_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pipe_op,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [31:0]       pipe_wdata,
    output logic              pipe_stall,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [1:0]        mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    dump_state_t       r_state;
    dump_state_t       w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              w_load;
    logic              w_word_done;
    logic              w_last;

    assign w_last = (r_addr == c_last_addr);

    word_tx_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .load_word (mem_rdata),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .word_done (w_word_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Termination relies only on the last-address compare, so the counter
    // never needs to wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if ((r_state == ST_IDLE) && dump_start) begin
            r_addr <= '0;
        end else if ((r_state == ST_SEND) && w_word_done && !w_last) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        dump_done  = 1'b0;
        dump_busy  = (r_state != ST_IDLE);
        pipe_stall = 1'b0;
        // Pipeline pass-through; the illegal code 2'b11 is presented to
        // memory as a plain idle.
        mem_op     = op_is_active(pipe_op) ? pipe_op : OP_IDLE;
        mem_addr   = pipe_addr;
        mem_wdata  = pipe_wdata;

        case (r_state)
            ST_IDLE: begin
                if (dump_start) begin
                    w_next = ST_RD;
                end
            end
            ST_RD: begin
                // The dump owns the memory port for exactly this cycle.
                mem_op     = OP_READ;
                mem_addr   = r_addr;
                mem_wdata  = '0;
                pipe_stall = op_is_active(pipe_op);
                w_next     = ST_CAP;
            end
            ST_CAP: begin
                w_load = 1'b1;
                w_next = ST_SEND;
            end
            ST_SEND: begin
                if (w_word_done) begin
                    w_next = w_last ? ST_DONE : ST_RD;
                end
            end
            ST_DONE: begin
                dump_done = 1'b1;
                w_next    = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule : dmem_dump_arbiter
`default_nettype wire

// File: tb/tb_dmem_dump_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_dump_arbiter
//  Purpose  : Directed self-checking bench for dmem_dump_arbiter with a
//             behavioural one-cycle-latency memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_dump_arbiter;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        pipe_op;
    logic [ADDR_W-1:0] pipe_addr;
    logic [31:0]       pipe_wdata;
    logic              pipe_stall;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_done;
    logic [1:0]        mem_op;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [31:0] mem [0:DEPTH-1];
    logic [31:0] exp_mem [0:DEPTH-1];
    logic [7:0]  rx_q [$];
    int          done_cnt    = 0;
    int          done_cyc    = 0;
    int          last_hs_cyc = 0;
    logic        hold_chk    = 1'b0;
    logic        prev_hold   = 1'b0;
    logic [7:0]  prev_data   = 8'h00;

    dmem_dump_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_op    (pipe_op),
        .pipe_addr  (pipe_addr),
        .pipe_wdata (pipe_wdata),
        .pipe_stall (pipe_stall),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: synchronous write, read data one cycle after the read.
    always @(posedge clk) begin
        if (mem_op == 2'b01) mem[mem_addr] <= mem_wdata;
        if (mem_op == 2'b10) mem_rdata <= mem[mem_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Byte / done monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (hold_chk && prev_hold) begin
            check_val("hold_valid", {31'd0, tx_valid}, 32'd1);
            check_val("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
        end
        if (tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            last_hs_cyc = cyc;
        end
        if (dump_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_hold = tx_valid && !tx_ready;
        prev_data = tx_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dump(output int start_cyc);
        dump_start = 1'b1;
        start_cyc  = cyc;
        tick();
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input bit rnd_ready);
        bit seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
            tick();
            if (done_cnt > base) begin
                seen = 1'b1;
                break;
            end
        end
        tx_ready = 1'b1;
        check_val("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic check_stream(input int base, input string name);
        logic [31:0] w;
        check_val({name, "_count"}, rx_q.size() - base, 32'd128);
        for (int k = 0; k < 128; k++) begin
            w = exp_mem[k / 4];
            if (base + k < rx_q.size())
                check_val($sformatf("%s_b%0d", name, k), {24'd0, rx_q[base + k]},
                          {24'd0, w[8*(3 - (k % 4)) +: 8]});
        end
    endtask

    initial begin
        int s_cyc;
        int base;
        int dbase;
        bit ok;

        rst        = 1'b1;
        pipe_op    = 2'b10;
        pipe_addr  = 5'd3;
        pipe_wdata = 32'h1234_5678;
        dump_start = 1'b0;
        tx_ready   = 1'b1;
        #2;
        // Outputs while reset is held.
        check_val("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_val("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check_val("rst_busy", {31'd0, dump_busy}, 32'd0);
        check_val("rst_done", {31'd0, dump_done}, 32'd0);
        check_val("rst_stall", {31'd0, pipe_stall}, 32'd0);
        check_val("rst_mem_op", {30'd0, mem_op}, 32'd2);
        check_val("rst_mem_addr", {27'd0, mem_addr}, 32'd3);
        check_val("rst_mem_wdata", mem_wdata, 32'h1234_5678);
        tick();
        tick();
        rst     = 1'b0;
        pipe_op = 2'b00;
        #1;
        check_val("idle_mem_op", {30'd0, mem_op}, 32'd0);

        // Preload memory through the idle pass-through path.
        for (int i = 0; i < DEPTH; i++) begin
            pipe_op    = 2'b01;
            pipe_addr  = ADDR_W'(i);
            pipe_wdata = 32'h1122_3300 + i;
            exp_mem[i] = 32'h1122_3300 + i;
            tick();
        end
        pipe_op = 2'b00;
        tick();

        // Plain dump, tx_ready high: latency, stream, length.
        base  = rx_q.size();
        dbase = done_cnt;
        start_dump(s_cyc);
        check_val("rd_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_val("rd_busy", {31'd0, dump_busy}, 32'd1);
        check_val("rd_mem_op", {30'd0, mem_op}, 32'd2);
        check_val("rd_mem_addr", {27'd0, mem_addr}, 32'd0);
        tick();
        check_val("cap_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_val("cap_mem_op", {30'd0, mem_op}, 32'd0);
        tick();
        check_val("send_tx_valid", {31'd0, tx_valid}, 32'd1);
        check_val("send_tx_data", {24'd0, tx_data}, 32'h11);
        wait_done(dbase, 1'b0);
        check_stream(base, "s1");
        check_val("s1_length", done_cyc - s_cyc, 32'd193);
        check_val("s1_done_after_last", done_cyc - last_hs_cyc, 32'd1);
        check_val("s1_idle_busy", {31'd0, dump_busy}, 32'd0);
        check_val("s1_done_cnt", done_cnt - dbase, 32'd1);

        // Pipeline read stalled in RD, write during SEND, ignored restart.
        base  = rx_q.size();
        dbase = done_cnt;
        start_dump(s_cyc);
        pipe_op   = 2'b10;
        pipe_addr = 5'd5;
        #1;
        check_val("arb_stall", {31'd0, pipe_stall}, 32'd1);
        check_val("arb_mem_addr_rd", {27'd0, mem_addr}, 32'd0);
        tick();
        check_val("arb_stall_cap", {31'd0, pipe_stall}, 32'd0);
        check_val("arb_mem_op_cap", {30'd0, mem_op}, 32'd2);
        check_val("arb_mem_addr_cap", {27'd0, mem_addr}, 32'd5);
        tick();
        pipe_op = 2'b00;
        check_val("arb_rdata5", mem_rdata, 32'h1122_3305);
        check_val("arb_first_byte", {24'd0, tx_data}, 32'h11);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if ((rx_q.size() - base >= 8) && tx_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check_val("reach_addr2", {31'd0, ok}, 32'd1);
        pipe_op    = 2'b01;
        pipe_addr  = 5'd31;
        pipe_wdata = 32'hDEAD_BEEF;
        dump_start = 1'b1;
        #1;
        check_val("wr_stall", {31'd0, pipe_stall}, 32'd0);
        check_val("wr_mem_op", {30'd0, mem_op}, 32'd1);
        check_val("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        pipe_op     = 2'b00;
        dump_start  = 1'b0;
        exp_mem[31] = 32'hDEAD_BEEF;
        wait_done(dbase, 1'b0);
        check_stream(base, "s2");
        for (int i = 0; i < 10; i++) tick();
        check_val("s2_one_done", done_cnt - dbase, 32'd1);
        check_val("s2_idle_busy", {31'd0, dump_busy}, 32'd0);

        // Random tx_ready with data-hold checking.
        base     = rx_q.size();
        dbase    = done_cnt;
        hold_chk = 1'b1;
        start_dump(s_cyc);
        wait_done(dbase, 1'b1);
        hold_chk = 1'b0;
        check_stream(base, "s3");

        // Reset while byte 2 of address 7 is pending.
        base  = rx_q.size();
        dbase = done_cnt;
        start_dump(s_cyc);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rx_q.size() - base >= 30) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tx_ready = 1'b0;
        check_val("reach_a7b2", {31'd0, ok}, 32'd1);
        check_val("a7b2_valid", {31'd0, tx_valid}, 32'd1);
        check_val("a7b2_data", {24'd0, tx_data}, 32'h33);
        rst = 1'b1;
        #1;
        check_val("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        check_val("mid_rst_busy", {31'd0, dump_busy}, 32'd0);
        check_val("mid_rst_data", {24'd0, tx_data}, 32'd0);
        tick();
        rst      = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_val("no_resume_busy", {31'd0, dump_busy}, 32'd0);
        check_val("no_resume_valid", {31'd0, tx_valid}, 32'd0);
        check_val("no_resume_done", done_cnt - dbase, 32'd0);
        base = rx_q.size();
        start_dump(s_cyc);
        wait_done(dbase, 1'b0);
        check_stream(base, "s4");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_dmem_dump_arbiter
`default_nettype wire
